// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding the UART transmitter: pops one byte at a time onto dintx/newd
// and holds the request until the transmitter reports the frame done.
module uart_tx_buffer #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic                    newd_o,
  output logic [DATA_WIDTH-1:0]   dintx_o,
  input  logic                    donetx_i,
  output logic                    busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    newd_q, newd_d;
  logic [DATA_WIDTH-1:0]   dintx_q, dintx_d;
  logic                    donetx_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic full, empty, push, pop, done_rise;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign push      = wr_en_i && !full;
  assign done_rise = donetx_i && !donetx_q;

  // State and control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      newd_q     <= 1'b0;
      dintx_q    <= '0;
      donetx_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      newd_q     <= newd_d;
      dintx_q    <= dintx_d;
      donetx_q   <= donetx_i;
    end
  end

  // Storage is deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty)    state_d = SEND;
      SEND:    if (done_rise) state_d = GAP;
      GAP:     if (!donetx_i) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    newd_d  = newd_q;
    dintx_d = dintx_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          newd_d  = 1'b1;
          dintx_d = mem_q[rd_ptr_q];
        end
      end
      SEND:    if (done_rise) newd_d = 1'b0;
      default: newd_d = newd_q;
    endcase
  end

  // A push while full is dropped regardless of a simultaneous pop
  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    overflow_d = overflow_q || (wr_en_i && full);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign newd_o     = newd_q;
  assign dintx_o    = dintx_q;
  assign busy_o     = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: random producer, a behavioural transmitter, and a
// scoreboard of expected bytes checked against every frame request.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full, empty, overflow, newd, busy;
  logic [4:0]    count;
  logic [DW-1:0] dintx;
  logic          donetx;

  uart_tx_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(overflow),
    .newd_o(newd), .dintx_o(dintx), .donetx_i(donetx), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: bytes the producer expects to see on dintx, in order
  logic [DW-1:0] exp_q[$];

  // Reference model state, written only by the monitor
  int            cnt_m = 0;
  bit            ovf_m = 0;
  bit            newd_m = 0;
  bit            gap_m = 0;
  bit            dprev_m = 0;
  logic [DW-1:0] dintx_m = '0;
  int            pop_cnt = 0;

  bit tx_stall = 0;
  bit tx_active = 0;
  int spur_req = 0;
  int spur_ack = 0;

  // Monitor: per edge, apply the handshake rules to the model and compare
  initial begin : monitor
    bit w_s, r_s, d_s, exp_pop, done_edge;
    int cnt_pre;
    forever begin
      @(posedge clk);
      w_s = wr_en; r_s = rst_n; d_s = donetx;
      #1;
      if (!r_s || !rst_n) begin
        cnt_m = 0; ovf_m = 0; newd_m = 0; gap_m = 0; dprev_m = 0; dintx_m = '0;
        exp_q.delete();
      end else begin
        cnt_pre   = cnt_m;
        exp_pop   = !newd_m && !gap_m && (cnt_pre > 0);
        done_edge = d_s && !dprev_m;
        if (w_s && cnt_pre == DEPTH) ovf_m = 1;
        cnt_m = cnt_pre + ((w_s && cnt_pre < DEPTH) ? 1 : 0) - (exp_pop ? 1 : 0);
        if (exp_pop) begin
          check("sb_has_byte", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) dintx_m = exp_q.pop_front();
          newd_m = 1;
          pop_cnt++;
        end else if (newd_m && done_edge) begin
          newd_m = 0;
          gap_m  = 1;
        end else if (gap_m && !d_s) begin
          gap_m = 0;
        end
        dprev_m = d_s;
        check("newd",     newd,     newd_m);
        check("dintx",    dintx,    dintx_m);
        check("count",    count,    cnt_m);
        check("full",     full,     cnt_m == DEPTH);
        check("empty",    empty,    cnt_m == 0);
        check("overflow", overflow, ovf_m);
        check("busy",     busy,     (cnt_m > 0) || newd_m || gap_m);
      end
    end
  end

  // Behavioural transmitter: random frame length, donetx high for 1..3 clk
  initial begin : transmitter
    donetx = 1'b0;
    forever begin
      @(negedge clk);
      if (newd && !tx_stall && rst_n) begin
        tx_active = 1;
        repeat ($urandom_range(2, 8)) @(negedge clk);
        donetx = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        donetx = 1'b0;
        tx_active = 0;
      end else if (spur_ack != spur_req) begin
        tx_active = 1;
        spur_ack++;
        donetx = 1'b1;
        repeat (2) @(negedge clk);
        donetx = 1'b0;
        tx_active = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic push(input logic [DW-1:0] b, input bit wait_nf);
    @(negedge clk);
    if (wait_nf) begin
      for (int k = 0; k < 500 && cnt_m >= DEPTH; k++) begin
        wr_en = 1'b0;
        @(negedge clk);
      end
    end
    wr_en   = 1'b1;
    wr_data = b;
    if (cnt_m < DEPTH) exp_q.push_back(b);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #2;
      if (!busy && exp_q.size() == 0 && !donetx && !tx_active && spur_ack == spur_req) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin : stimulus
    int peak, saved;
    bit ok;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0;

    // Reset held with wr_en toggling
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      wr_en = ~wr_en;
      wr_data = DW'($urandom);
    end
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_newd", newd, 0);
    check("rst_dintx", dintx, 8'h00);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    idle_cycles(3);

    // Single byte latency
    push(8'hA5, 0);
    @(posedge clk); #1;
    check("single_empty_after_N", empty, 0);
    check("single_newd_after_N", newd, 0);
    idle_cycles(1);
    @(posedge clk); #1;
    check("single_newd_after_N1", newd, 1);
    check("single_dintx", dintx, 8'hA5);
    wait_idle("single_drain");

    // Burst of three, count peaks at 2
    peak = 0;
    push(8'h01, 0);
    @(posedge clk); #1; if (count > peak) peak = count;
    push(8'h02, 0);
    @(posedge clk); #1; if (count > peak) peak = count;
    push(8'h03, 0);
    @(posedge clk); #1; if (count > peak) peak = count;
    idle_cycles(1);
    @(posedge clk); #1; if (count > peak) peak = count;
    check("burst_peak", peak, 2);
    wait_idle("burst_drain");
    check("burst_empty", empty, 1);
    check("burst_busy", busy, 0);

    // donetx while idle must be ignored
    spur_req++;
    idle_cycles(8);
    check("spur_newd", newd, 0);
    check("spur_busy", busy, 0);
    wait_idle("spur_done");

    // Fill with transmitter stalled, then overflow
    tx_stall = 1;
    for (int i = 0; i <= 16; i++) push(DW'(i), 0);
    @(posedge clk); #1;
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_overflow", overflow, 0);
    check("fill_dintx_first", dintx, 8'h00);
    push(8'h11, 0);
    @(posedge clk); #1;
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 16);
    idle_cycles(1);
    tx_stall = 0;
    wait_idle("fill_drain");
    check("ovf_sticky", overflow, 1);

    // 40 bytes through a 16-deep FIFO: pointers wrap
    for (int i = 0; i < 40; i++) begin
      idle_cycles($urandom_range(0, 2));
      push(DW'(i), 1);
    end
    idle_cycles(1);
    wait_idle("wrap_drain");

    // Random bytes, random gaps, full allowed to drop pushes
    for (int i = 0; i < 60; i++) begin
      idle_cycles($urandom_range(0, 3));
      push(DW'($urandom), 0);
    end
    idle_cycles(1);
    wait_idle("random_drain");

    // Reset during the second frame's request
    saved = pop_cnt;
    for (int i = 0; i < 5; i++) push(DW'(8'hC0 + i), 0);
    idle_cycles(1);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (pop_cnt >= saved + 2) begin ok = 1; break; end
    end
    check("mid_second_frame", ok, 1);
    #1;
    check("mid_newd_before", newd, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_newd", newd, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overflow", overflow, 0);
    idle_cycles(2);
    rst_n = 1'b1;
    saved = pop_cnt;
    idle_cycles(30);
    check("post_rst_no_newd", pop_cnt - saved, 0);
    check("post_rst_newd_low", newd, 0);
    push(8'h5A, 0);
    idle_cycles(1);
    @(posedge clk); #1;
    check("post_rst_newd", newd, 1);
    check("post_rst_dintx", dintx, 8'h5A);
    wait_idle("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
